// File: rtl/prefix_pkg.sv
// Shared token definitions and helpers for the infix-to-prefix converter and
// the downstream prefix evaluator.
package prefix_pkg;

  localparam int unsigned TOK_W = 5;
  localparam int unsigned N_TOK = 19;
  localparam int unsigned STK_D = 9;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // Bit 4 marks an operator token; operands carry their value in [3:0].
  function automatic logic is_op(input logic [TOK_W-1:0] tok);
    return tok[TOK_W-1];
  endfunction

  // 1 for '*' and '/', 0 for '+' and '-'.
  function automatic logic prec(input logic [TOK_W-1:0] tok);
    return (tok[1:0] == OP_MUL) || (tok[1:0] == OP_DIV);
  endfunction

endpackage

// File: rtl/op_stack.sv
// Single-port LIFO for operator tokens: one push or one pop per cycle.
module op_stack #(
  parameter int unsigned DEPTH = 9,
  parameter int unsigned W     = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty
);

  localparam int unsigned SP_W = $clog2(DEPTH + 1);
  localparam logic [SP_W-1:0] FULL = SP_W'(DEPTH);

  logic [W-1:0]    mem [DEPTH];
  logic [SP_W-1:0] sp;

  assign empty = (sp == '0);
  assign top   = empty ? '0 : mem[sp - SP_W'(1)];

  // Stack pointer and storage; push has priority, full/empty guard keeps sp in range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && sp != FULL) begin
      mem[sp] <= push_data;
      sp      <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

  // The converter never pops an empty stack nor pushes a full one.
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && sp == FULL));

endmodule

// File: rtl/infix_to_prefix.sv
// Converts a 19-token infix frame to prefix order (reverse-scan shunting-yard)
// and streams the result out as a contiguous 19-cycle valid/data burst.
module infix_to_prefix
  import prefix_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [TOK_W-1:0] in_data,
  output logic             out_valid,
  output logic [TOK_W-1:0] out_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CONV  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam int unsigned IDX_W = $clog2(N_TOK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TOK - 1);

  logic [2:0]       state;
  logic [TOK_W-1:0] in_buf  [0:N_TOK-1];
  logic [TOK_W-1:0] out_buf [0:N_TOK-1];
  logic [IDX_W-1:0] cnt, rd_idx, wr_idx, oidx;

  logic [TOK_W-1:0] tok, stk_top, emit_tok;
  logic             stk_push, stk_pop, stk_empty, emit, advance;

  assign tok = in_buf[rd_idx];

  op_stack #(.DEPTH(STK_D), .W(TOK_W)) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (tok),
    .top       (stk_top),
    .empty     (stk_empty)
  );

  // Per-cycle conversion action: stack control, out_buf write and scan advance.
  always_comb begin
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    emit     = 1'b0;
    emit_tok = tok;
    advance  = 1'b0;
    case (state)
      S_CONV: begin
        if (!is_op(tok)) begin
          emit    = 1'b1;
          advance = 1'b1;
        end else if (!stk_empty && (prec(stk_top) > prec(tok))) begin
          stk_pop  = 1'b1;
          emit     = 1'b1;
          emit_tok = stk_top;
        end else begin
          stk_push = 1'b1;
          advance  = 1'b1;
        end
      end
      S_FLUSH: begin
        stk_pop  = !stk_empty;
        emit     = !stk_empty;
        emit_tok = stk_top;
      end
      default: ;
    endcase
  end

  // FSM, frame buffers, indices and registered output port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rd_idx    <= '0;
      wr_idx    <= '0;
      oidx      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int unsigned i = 0; i < N_TOK; i++) begin
        in_buf[i]  <= '0;
        out_buf[i] <= '0;
      end
    end else begin
      out_valid <= (state == S_OUT);
      out_data  <= (state == S_OUT) ? out_buf[oidx] : '0;

      if (emit) begin
        out_buf[wr_idx] <= emit_tok;
        wr_idx          <= wr_idx + IDX_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (in_valid) begin
            in_buf[0] <= in_data;
            cnt       <= IDX_W'(1);
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (cnt <= LAST_IDX) begin
              in_buf[cnt] <= in_data;
              cnt         <= cnt + IDX_W'(1);
            end
          end else begin
            state  <= S_CONV;
            rd_idx <= LAST_IDX;
            wr_idx <= '0;
            cnt    <= '0;
          end
        end
        S_CONV: begin
          if (advance) begin
            if (rd_idx == '0) state <= S_FLUSH;
            else              rd_idx <= rd_idx - IDX_W'(1);
          end
        end
        S_FLUSH: begin
          if (stk_empty) begin
            state <= S_OUT;
            oidx  <= LAST_IDX;
          end
        end
        S_OUT: begin
          if (oidx == '0) state <= S_IDLE;
          else            oidx  <= oidx - IDX_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
